// File: rtl/iq_filter_seq_if.sv
// Bus bundle between the IQ filter sequencer, the ADC front end and the I/Q filter pair.
// slave = sequencer view, master = environment (ADC + filters) view.
interface iq_filter_seq_if #(
   parameter int DATA_W = 5
);
   logic              adc_valid;
   logic [DATA_W-1:0] adc_i;
   logic [DATA_W-1:0] adc_q;
   logic              adc_ready;
   logic              filt_in_valid;
   logic [DATA_W-1:0] filt_in_i;
   logic [DATA_W-1:0] filt_in_q;
   logic              filt_out_valid_i;
   logic              filt_out_valid_q;
   logic [DATA_W-1:0] filt_out_i;
   logic [DATA_W-1:0] filt_out_q;
   logic              iq_valid;
   logic [DATA_W-1:0] iq_i;
   logic [DATA_W-1:0] iq_q;

   modport slave (
      input  adc_valid, adc_i, adc_q,
      output adc_ready,
      output filt_in_valid, filt_in_i, filt_in_q,
      input  filt_out_valid_i, filt_out_valid_q, filt_out_i, filt_out_q,
      output iq_valid, iq_i, iq_q
   );

   modport master (
      output adc_valid, adc_i, adc_q,
      input  adc_ready,
      input  filt_in_valid, filt_in_i, filt_in_q,
      output filt_out_valid_i, filt_out_valid_q, filt_out_i, filt_out_q,
      input  iq_valid, iq_i, iq_q
   );
endinterface

// File: rtl/iq_filter_seq.sv
// I/Q channel-filter sequencer: buffers ADC pairs, issues them on a fixed slot cadence
// to both filters and re-pairs the two filter outputs, flagging I/Q desync.
module iq_filter_seq #(
   parameter int DATA_W       = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int FRAME_LEN    = 5,
   parameter int ACTIVE_SLOTS = 4,
   parameter int SKEW_MAX     = 3
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   input  logic                err_clr,
   iq_filter_seq_if.slave      bus,
   output logic                sync_err,
   output logic                overflow,
   output logic [7:0]          underrun_cnt
);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int SLOT_W = $clog2(FRAME_LEN);
   localparam int SKEW_W = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] i;
      logic [DATA_W-1:0] q;
   } pair_t;

   typedef enum logic [1:0] {WAIT_BOTH, HAVE_I, HAVE_Q} pair_st_t;

   // ---------------- input FIFO + issue cadence ----------------
   pair_t             mem_q [FIFO_DEPTH];
   pair_t             mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic              filt_in_valid_q, filt_in_valid_d;
   pair_t             filt_in_q, filt_in_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        underrun_cnt_q, underrun_cnt_d;
   logic              full, empty, push, pop, slot_active, underrun;

   assign full        = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   // Push is gated by full alone: a same-cycle pop never makes room for a push.
   assign push        = bus.adc_valid && !full;
   assign slot_active = enable && (slot_cnt_q < SLOT_W'(ACTIVE_SLOTS));
   assign pop         = slot_active && !empty;
   assign underrun    = slot_active && empty;

   always_comb begin
      mem_d           = mem_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
      slot_cnt_d      = '0;
      filt_in_valid_d = pop;
      filt_in_d       = filt_in_q;
      overflow_d      = overflow_q;
      underrun_cnt_d  = underrun_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{i: bus.adc_i, q: bus.adc_q};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         filt_in_d = mem_q[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end
      if (enable && (slot_cnt_q != SLOT_W'(FRAME_LEN - 1)))
         slot_cnt_d = slot_cnt_q + SLOT_W'(1);
      // Clear first so a same-cycle set event takes precedence.
      if (err_clr) begin
         overflow_d     = 1'b0;
         underrun_cnt_d = '0;
      end
      if (bus.adc_valid && full) overflow_d = 1'b1;
      if (underrun && (underrun_cnt_d != 8'hFF)) underrun_cnt_d = underrun_cnt_d + 8'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         slot_cnt_q      <= '0;
         filt_in_valid_q <= 1'b0;
         filt_in_q       <= '0;
         overflow_q      <= 1'b0;
         underrun_cnt_q  <= '0;
      end else begin
         mem_q           <= mem_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         slot_cnt_q      <= slot_cnt_d;
         filt_in_valid_q <= filt_in_valid_d;
         filt_in_q       <= filt_in_d;
         overflow_q      <= overflow_d;
         underrun_cnt_q  <= underrun_cnt_d;
      end
   end

   // ---------------- output re-pairing FSM ----------------
   pair_st_t          st_q, st_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [SKEW_W-1:0] skew_q, skew_d;
   logic              iq_valid_q, iq_valid_d;
   pair_t             iq_q, iq_d;
   logic              sync_err_q, sync_err_d;
   logic              sync_set;
   logic              vi, vq;

   assign vi = bus.filt_out_valid_i;
   assign vq = bus.filt_out_valid_q;

   always_comb begin
      st_d       = st_q;
      hold_d     = hold_q;
      skew_d     = skew_q;
      iq_valid_d = 1'b0;
      iq_d       = iq_q;
      sync_set   = 1'b0;
      case (st_q)
         WAIT_BOTH: begin
            if (vi && vq) begin
               iq_valid_d = 1'b1;
               iq_d       = '{i: bus.filt_out_i, q: bus.filt_out_q};
            end else if (vi) begin
               hold_d = bus.filt_out_i;
               skew_d = '0;
               st_d   = HAVE_I;
            end else if (vq) begin
               hold_d = bus.filt_out_q;
               skew_d = '0;
               st_d   = HAVE_Q;
            end
         end
         HAVE_I: begin
            if (vi) begin
               // A second I before its Q: the older I is orphaned.
               sync_set = 1'b1;
               if (vq) begin
                  iq_valid_d = 1'b1;
                  iq_d       = '{i: bus.filt_out_i, q: bus.filt_out_q};
                  st_d       = WAIT_BOTH;
               end else begin
                  hold_d = bus.filt_out_i;
                  skew_d = '0;
               end
            end else if (vq) begin
               iq_valid_d = 1'b1;
               iq_d       = '{i: hold_q, q: bus.filt_out_q};
               st_d       = WAIT_BOTH;
            end else if (skew_q == SKEW_W'(SKEW_MAX - 1)) begin
               sync_set = 1'b1;
               st_d     = WAIT_BOTH;
            end else begin
               skew_d = skew_q + SKEW_W'(1);
            end
         end
         HAVE_Q: begin
            if (vq) begin
               sync_set = 1'b1;
               if (vi) begin
                  iq_valid_d = 1'b1;
                  iq_d       = '{i: bus.filt_out_i, q: bus.filt_out_q};
                  st_d       = WAIT_BOTH;
               end else begin
                  hold_d = bus.filt_out_q;
                  skew_d = '0;
               end
            end else if (vi) begin
               iq_valid_d = 1'b1;
               iq_d       = '{i: bus.filt_out_i, q: hold_q};
               st_d       = WAIT_BOTH;
            end else if (skew_q == SKEW_W'(SKEW_MAX - 1)) begin
               sync_set = 1'b1;
               st_d     = WAIT_BOTH;
            end else begin
               skew_d = skew_q + SKEW_W'(1);
            end
         end
         default: st_d = WAIT_BOTH;
      endcase
      sync_err_d = sync_set ? 1'b1 : (err_clr ? 1'b0 : sync_err_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q       <= WAIT_BOTH;
         hold_q     <= '0;
         skew_q     <= '0;
         iq_valid_q <= 1'b0;
         iq_q       <= '0;
         sync_err_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         hold_q     <= hold_d;
         skew_q     <= skew_d;
         iq_valid_q <= iq_valid_d;
         iq_q       <= iq_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign bus.adc_ready     = !full;
   assign bus.filt_in_valid = filt_in_valid_q;
   assign bus.filt_in_i     = filt_in_q.i;
   assign bus.filt_in_q     = filt_in_q.q;
   assign bus.iq_valid      = iq_valid_q;
   assign bus.iq_i          = iq_q.i;
   assign bus.iq_q          = iq_q.q;
   assign sync_err          = sync_err_q;
   assign overflow          = overflow_q;
   assign underrun_cnt      = underrun_cnt_q;
endmodule

// File: tb/tb_iq_filter_seq.sv
// Directed bench for iq_filter_seq: reset, issue cadence, overflow/underrun, I/Q pairing.
module tb_iq_filter_seq;
   logic       clk = 1'b0;
   logic       resetn, enable, err_clr;
   logic       sync_err, overflow;
   logic [7:0] underrun_cnt;
   int         total = 0;
   int         bad   = 0;

   iq_filter_seq_if #(.DATA_W(5)) bus ();

   iq_filter_seq #(
      .DATA_W(5), .FIFO_DEPTH(4), .FRAME_LEN(5), .ACTIVE_SLOTS(4), .SKEW_MAX(3)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .err_clr(err_clr),
      .bus(bus), .sync_err(sync_err), .overflow(overflow), .underrun_cnt(underrun_cnt)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   logic [0:9] vld_exp;
   int         n, issued;
   logic       seen_full;

   initial begin
      resetn = 1'b0; enable = 1'b0; err_clr = 1'b0;
      bus.adc_valid = 1'b0; bus.adc_i = '0; bus.adc_q = '0;
      bus.filt_out_valid_i = 1'b0; bus.filt_out_valid_q = 1'b0;
      bus.filt_out_i = '0; bus.filt_out_q = '0;

      // reset asserted mid-stream, between clock edges
      #2 resetn = 1'b1; enable = 1'b1;
      bus.adc_valid = 1'b1; bus.adc_i = 5'd1; bus.adc_q = 5'd30;
      @(negedge clk);
      bus.adc_i = 5'd2; bus.adc_q = 5'd29;
      #14;
      chk("pre_vld", bus.filt_in_valid, 1);
      chk("pre_i", bus.filt_in_i, 1);
      chk("pre_q", bus.filt_in_q, 30);
      chk("pre_und", underrun_cnt, 1);
      #1 resetn = 1'b0;
      #1;
      chk("rst_rdy", bus.adc_ready, 1);
      chk("rst_fvld", bus.filt_in_valid, 0);
      chk("rst_fi", bus.filt_in_i, 0);
      chk("rst_fq", bus.filt_in_q, 0);
      chk("rst_iqv", bus.iq_valid, 0);
      chk("rst_iqi", bus.iq_i, 0);
      chk("rst_iqq", bus.iq_q, 0);
      chk("rst_sync", sync_err, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_und", underrun_cnt, 0);
      #9 resetn = 1'b1; enable = 1'b0; bus.adc_valid = 1'b0;
      @(negedge clk);

      // cadence: 4 of 5 slots, first slot underruns on the empty FIFO
      vld_exp   = 10'b0111011110;
      n         = 1;
      issued    = 0;
      seen_full = 1'b0;
      enable    = 1'b1;
      for (int k = 0; k < 120 && issued < 20; k++) begin
         bus.adc_valid = (n <= 20) && bus.adc_ready;
         bus.adc_i     = n[4:0];
         bus.adc_q     = ~n[4:0];
         step();
         if (bus.adc_valid) n++;
         if (!bus.adc_ready) seen_full = 1'b1;
         if (k < 10) chk("cad_vld", bus.filt_in_valid, vld_exp[k]);
         if (bus.filt_in_valid) begin
            issued++;
            chk("cad_i", bus.filt_in_i, issued);
            chk("cad_q", bus.filt_in_q, 32'(5'(~issued[4:0])));
         end
      end
      chk("cad_cnt", issued, 20);
      chk("cad_full", seen_full, 1);
      chk("cad_ovf", overflow, 0);
      bus.adc_valid = 1'b0;
      enable = 1'b0;
      step();
      chk("hold_vld", bus.filt_in_valid, 0);
      chk("hold_i", bus.filt_in_i, 20);

      // overflow with the issue side held, then drain into an underrun
      pulse_clr();
      chk("clr_und", underrun_cnt, 0);
      for (int j = 0; j < 5; j++) begin
         bus.adc_valid = 1'b1;
         bus.adc_i     = 5'(21 + j);
         step();
         if (j == 3) begin
            chk("ovf_rdy", bus.adc_ready, 0);
            chk("ovf_pre", overflow, 0);
         end
      end
      chk("ovf_set", overflow, 1);
      bus.adc_valid = 1'b0;
      enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         if (k < 4) begin
            chk("drain_vld", bus.filt_in_valid, 1);
            chk("drain_i", bus.filt_in_i, 21 + k);
         end else begin
            chk("drain_gap", bus.filt_in_valid, 0);
            chk("drain_und", underrun_cnt, (k == 5) ? 1 : 0);
         end
      end
      enable = 1'b0;
      chk("ovf_sticky", overflow, 1);
      pulse_clr();
      chk("ovf_clr", overflow, 0);
      chk("und_clr", underrun_cnt, 0);

      // pairing: Q two cycles after I
      bus.filt_out_valid_i = 1'b1; bus.filt_out_i = 5'd5;
      step();
      bus.filt_out_valid_i = 1'b0;
      chk("pair_no1", bus.iq_valid, 0);
      step();
      chk("pair_no2", bus.iq_valid, 0);
      bus.filt_out_valid_q = 1'b1; bus.filt_out_q = 5'h1D;
      step();
      bus.filt_out_valid_q = 1'b0;
      chk("pair_vld", bus.iq_valid, 1);
      chk("pair_i", bus.iq_i, 5);
      chk("pair_q", bus.iq_q, 32'h1D);
      chk("pair_sync", sync_err, 0);
      step();
      chk("pair_pulse", bus.iq_valid, 0);
      chk("pair_hold", bus.iq_i, 5);

      // simultaneous extremes
      bus.filt_out_valid_i = 1'b1; bus.filt_out_i = 5'h10;
      bus.filt_out_valid_q = 1'b1; bus.filt_out_q = 5'h0F;
      step();
      bus.filt_out_valid_i = 1'b0; bus.filt_out_valid_q = 1'b0;
      chk("sim_vld", bus.iq_valid, 1);
      chk("sim_i", bus.iq_i, 32'h10);
      chk("sim_q", bus.iq_q, 32'h0F);

      // skew timeout: I alone for three cycles
      bus.filt_out_valid_i = 1'b1; bus.filt_out_i = 5'd7;
      step();
      bus.filt_out_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("skew_iqv", bus.iq_valid, 0);
         chk("skew_sync", sync_err, (k == 2) ? 1 : 0);
      end
      pulse_clr();
      chk("skew_clr", sync_err, 0);

      // double I: second I pairs with the next Q
      bus.filt_out_valid_i = 1'b1; bus.filt_out_i = 5'd3;
      step();
      bus.filt_out_i = 5'd9;
      step();
      bus.filt_out_valid_i = 1'b0;
      chk("dbl_sync", sync_err, 1);
      chk("dbl_noiq", bus.iq_valid, 0);
      bus.filt_out_valid_q = 1'b1; bus.filt_out_q = 5'h19;
      step();
      bus.filt_out_valid_q = 1'b0;
      chk("dbl_vld", bus.iq_valid, 1);
      chk("dbl_i", bus.iq_i, 9);
      chk("dbl_q", bus.iq_q, 32'h19);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
